// File: rtl/melody_pkg.sv
// Shared note codes, per-note tone divisors and sequencer state encodings
// for the melody playback path.
package melody_pkg;

    typedef enum logic [2:0] {
        NOTE_REST = 3'd0,
        NOTE_DO   = 3'd1,
        NOTE_RE   = 3'd2,
        NOTE_MI   = 3'd3,
        NOTE_FA   = 3'd4,
        NOTE_SOL  = 3'd5,
        NOTE_LA   = 3'd6,
        NOTE_SI   = 3'd7
    } note_t;

    typedef struct packed {
        note_t      note;
        logic [1:0] beats;
    } rom_entry_t;

    // Tone periods in 50 MHz clock cycles; also used by the per-note dividers.
    localparam logic [27:0] DIV_DO  = 28'd381679;
    localparam logic [27:0] DIV_RE  = 28'd340530;
    localparam logic [27:0] DIV_MI  = 28'd303379;
    localparam logic [27:0] DIV_FA  = 28'd286352;
    localparam logic [27:0] DIV_SOL = 28'd255102;
    localparam logic [27:0] DIV_LA  = 28'd227273;
    localparam logic [27:0] DIV_SI  = 28'd202478;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_TONE = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    function automatic logic [27:0] note_divisor(input note_t n);
        case (n)
            NOTE_DO:  return DIV_DO;
            NOTE_RE:  return DIV_RE;
            NOTE_MI:  return DIV_MI;
            NOTE_FA:  return DIV_FA;
            NOTE_SOL: return DIV_SOL;
            NOTE_LA:  return DIV_LA;
            NOTE_SI:  return DIV_SI;
            default:  return 28'd0;
        endcase
    endfunction

endpackage

// File: rtl/melody_rom.sv
// Song content: step index to {note, beats}. One port for the playing step,
// one for the step about to start so boundaries need no dead cycle.
module melody_rom
    import melody_pkg::*;
(
    input  logic [2:0] cur_idx,
    input  logic [2:0] nxt_idx,
    output note_t      cur_note,
    output logic [1:0] cur_beats,
    output note_t      nxt_note
);

    function automatic rom_entry_t lookup(input logic [2:0] idx);
        case (idx)
            3'd0:    return '{NOTE_DO,   2'd1};
            3'd1:    return '{NOTE_RE,   2'd1};
            3'd2:    return '{NOTE_MI,   2'd1};
            3'd3:    return '{NOTE_FA,   2'd1};
            3'd4:    return '{NOTE_SOL,  2'd2};
            3'd5:    return '{NOTE_LA,   2'd1};
            3'd6:    return '{NOTE_SI,   2'd1};
            default: return '{NOTE_REST, 2'd1};
        endcase
    endfunction

    rom_entry_t cur_entry;
    rom_entry_t nxt_entry;

    assign cur_entry = lookup(cur_idx);
    assign nxt_entry = lookup(nxt_idx);

    assign cur_note  = cur_entry.note;
    assign cur_beats = cur_entry.beats;
    assign nxt_note  = nxt_entry.note;

endmodule

// File: rtl/melody_sequencer.sv
// Plays the 8-step melody table: each note sounds, then falls silent for the
// articulation gap, for a whole number of beats. Supports stop and looping.
module melody_sequencer
    import melody_pkg::*;
#(
    parameter logic [27:0] BEAT_TICKS = 28'd12500000,
    parameter logic [27:0] GAP_TICKS  = 28'd1250000
) (
    input  logic        clock_in,
    input  logic        reset,
    input  logic        start,
    input  logic        stop,
    input  logic        loop_en,
    output logic [27:0] divisor,
    output logic        gate,
    output logic [2:0]  step,
    output logic        busy,
    output logic        done
);

    logic [1:0]  state_q, state_d;
    logic [2:0]  step_q, step_d;
    logic [27:0] tick_q, tick_d;
    logic [27:0] divisor_q, divisor_d;
    logic        gate_q, gate_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    note_t       cur_note;
    note_t       nxt_note;
    logic [1:0]  cur_beats;
    logic [2:0]  nxt_step;
    logic [27:0] dur_ticks;
    logic [27:0] tone_last;
    logic [27:0] gap_last;

    // From IDLE the next note is always step 0; otherwise the 3-bit add wraps 7 -> 0.
    assign nxt_step = (state_q == ST_IDLE) ? 3'd0 : step_q + 3'd1;

    melody_rom u_rom (
        .cur_idx   (step_q),
        .nxt_idx   (nxt_step),
        .cur_note  (cur_note),
        .cur_beats (cur_beats),
        .nxt_note  (nxt_note)
    );

    assign dur_ticks = (cur_beats == 2'd2) ? {BEAT_TICKS[26:0], 1'b0} : BEAT_TICKS;
    assign tone_last = dur_ticks - GAP_TICKS - 28'd1;
    assign gap_last  = dur_ticks - 28'd1;

    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        tick_d    = tick_q;
        divisor_d = divisor_q;
        gate_d    = gate_q;
        busy_d    = busy_q;
        done_d    = 1'b0;

        if (stop) begin
            state_d   = ST_IDLE;
            step_d    = 3'd0;
            tick_d    = 28'd0;
            divisor_d = 28'd0;
            gate_d    = 1'b0;
            busy_d    = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_d   = ST_TONE;
                        step_d    = 3'd0;
                        tick_d    = 28'd0;
                        busy_d    = 1'b1;
                        divisor_d = note_divisor(nxt_note);
                        gate_d    = (nxt_note != NOTE_REST);
                    end
                end
                ST_TONE: begin
                    tick_d = tick_q + 28'd1;
                    if (tick_q == tone_last) begin
                        state_d = ST_GAP;
                        gate_d  = 1'b0;
                    end
                end
                ST_GAP: begin
                    tick_d = tick_q + 28'd1;
                    if (tick_q == gap_last) begin
                        tick_d = 28'd0;
                        if (step_q == 3'd7 && !loop_en) begin
                            state_d   = ST_IDLE;
                            step_d    = 3'd0;
                            divisor_d = 28'd0;
                            gate_d    = 1'b0;
                            busy_d    = 1'b0;
                            done_d    = 1'b1;
                        end else begin
                            state_d   = ST_TONE;
                            step_d    = nxt_step;
                            divisor_d = note_divisor(nxt_note);
                            gate_d    = (nxt_note != NOTE_REST);
                        end
                    end
                end
                default: begin
                    state_d   = ST_IDLE;
                    step_d    = 3'd0;
                    tick_d    = 28'd0;
                    divisor_d = 28'd0;
                    gate_d    = 1'b0;
                    busy_d    = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clock_in) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            step_q    <= 3'd0;
            tick_q    <= 28'd0;
            divisor_q <= 28'd0;
            gate_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            step_q    <= step_d;
            tick_q    <= tick_d;
            divisor_q <= divisor_d;
            gate_q    <= gate_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign divisor = divisor_q;
    assign gate    = gate_q;
    assign step    = step_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_melody_sequencer.sv
// Directed bench for melody_sequencer with BEAT_TICKS=10, GAP_TICKS=2
// (one pass = 90 cycles); outputs are sampled on the falling edge.
module tb_melody_sequencer;

    logic        clock_in = 1'b0;
    logic        reset    = 1'b1;
    logic        start    = 1'b0;
    logic        stop     = 1'b0;
    logic        loop_en  = 1'b0;
    logic [27:0] divisor;
    logic        gate;
    logic [2:0]  step;
    logic        busy;
    logic        done;

    int checks   = 0;
    int failures = 0;

    int          beats_t [8] = '{1, 1, 1, 1, 2, 1, 1, 1};
    logic [27:0] div_t   [8] = '{28'd381679, 28'd340530, 28'd303379, 28'd286352,
                                 28'd255102, 28'd227273, 28'd202478, 28'd0};

    melody_sequencer #(
        .BEAT_TICKS (28'd10),
        .GAP_TICKS  (28'd2)
    ) dut (
        .clock_in (clock_in),
        .reset    (reset),
        .start    (start),
        .stop     (stop),
        .loop_en  (loop_en),
        .divisor  (divisor),
        .gate     (gate),
        .step     (step),
        .busy     (busy),
        .done     (done)
    );

    always #5 clock_in = ~clock_in;

    task automatic cyc();
        @(posedge clock_in);
        @(negedge clock_in);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Expected outputs for the k-th cycle (1-based) after a start, from the song table.
    task automatic model(input int k, output logic [2:0] s, output logic g, output logic [27:0] d);
        int o;
        int base;
        o    = (k - 1) % 90;
        base = 0;
        s    = 3'd0;
        g    = 1'b0;
        d    = 28'd0;
        for (int i = 0; i < 8; i++) begin
            int len;
            len = beats_t[i] * 10;
            if (o >= base && o < base + len) begin
                s = 3'(i);
                d = div_t[i];
                g = (d != 28'd0) && (o - base < len - 2);
            end
            base += len;
        end
    endtask

    task automatic check_play(input int k, input string tag);
        logic [2:0]  es;
        logic        eg;
        logic [27:0] ed;
        model(k, es, eg, ed);
        chk({tag, "_step"}, 32'(step), 32'(es));
        chk({tag, "_gate"}, 32'(gate), 32'(eg));
        chk({tag, "_div"},  32'(divisor), 32'(ed));
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        chk({tag, "_done"}, 32'(done), 32'd0);
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_div"},  32'(divisor), 32'd0);
        chk({tag, "_gate"}, 32'(gate), 32'd0);
        chk({tag, "_step"}, 32'(step), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
    endtask

    initial begin
        int sol_cnt;
        int done_cnt;

        // Reset and idle
        repeat (2) cyc();
        check_idle("reset");
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            check_idle("idle");
        end

        // Non-looping pass, with an ignored start during step 2
        sol_cnt = 0;
        start = 1'b1;
        cyc();
        start = 1'b0;
        for (int k = 1; k <= 90; k++) begin
            if (k > 1) cyc();
            check_play(k, "pass1");
            if (step == 3'd4 && gate) sol_cnt++;
            start = (k == 22);
        end
        chk("sol_gate_cycles", 32'(sol_cnt), 32'd18);
        cyc();
        chk("done_pulse", 32'(done), 32'd1);
        chk("done_busy", 32'(busy), 32'd0);
        chk("done_gate", 32'(gate), 32'd0);
        chk("done_div", 32'(divisor), 32'd0);
        chk("done_step", 32'(step), 32'd0);
        cyc();
        check_idle("after_done");

        // Looping playback, stopped during step 3 of the third pass
        done_cnt = 0;
        loop_en = 1'b1;
        start = 1'b1;
        cyc();
        start = 1'b0;
        for (int k = 1; k <= 214; k++) begin
            if (k > 1) cyc();
            check_play(k, "loop");
            if (done) done_cnt++;
        end
        chk("loop_no_done", 32'(done_cnt), 32'd0);
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        loop_en = 1'b0;
        check_idle("stop");
        cyc();
        check_idle("stop_after");

        // start and stop together while idle
        start = 1'b1;
        stop = 1'b1;
        cyc();
        start = 1'b0;
        stop = 1'b0;
        check_idle("start_stop");
        cyc();
        check_idle("start_stop_after");

        // Reset asserted during step 5
        start = 1'b1;
        cyc();
        start = 1'b0;
        for (int k = 1; k <= 62; k++) begin
            if (k > 1) cyc();
            check_play(k, "pre_reset");
        end
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        check_idle("mid_reset");
        cyc();
        check_idle("post_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
